// File: rtl/seq_divider_16by8.sv
// ----------------------------------------------------------------------------
// seq_divider_16by8
//   Sequential radix-2 restoring divider. Divides an unsigned DIVIDEND_W-bit
//   dividend by an unsigned DIVISOR_W-bit divisor and produces one quotient
//   bit per clock. q * divisor + r reproduces the dividend, so products from
//   the 8x8 multiplier datapath round-trip through this block.
//
//   Parameters
//     DIVIDEND_W  dividend/quotient width and iteration count (default 16)
//     DIVISOR_W   divisor/remainder width, <= DIVIDEND_W      (default 8)
//
//   Ports
//     clk        rising-edge clock
//     rst_n      asynchronous active-low reset
//     in_valid   operand pair presented
//     in_ready   divider idle and able to accept operands
//     dividend   unsigned dividend, sampled on in_valid && in_ready
//     divisor    unsigned divisor,  sampled on in_valid && in_ready
//     out_valid  result valid, held until out_ready
//     out_ready  consumer accepts result
//     quotient   unsigned quotient
//     remainder  unsigned remainder
//     div_zero   (DIV_ZERO_ERR_EN only) result came from a zero divisor
//
//   Optional feature macro: DIV_ZERO_ERR_EN
//     Defined   - div_zero port present; a zero divisor skips the iteration
//                 and completes with latency 1.
//     Undefined - a zero divisor runs the full iteration (all trials pass).
//
//   Timing: accept edge -> out_valid high is DIVIDEND_W+1 clocks. The last
//   of those clocks is the result write into the output registers in DONE.
// ----------------------------------------------------------------------------
module seq_divider_16by8 #(
    parameter int DIVIDEND_W = 16,
    parameter int DIVISOR_W  = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DIVIDEND_W-1:0] dividend,
    input  logic [DIVISOR_W-1:0]  divisor,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DIVIDEND_W-1:0] quotient,
    output logic [DIVISOR_W-1:0]  remainder
`ifdef DIV_ZERO_ERR_EN
    ,
    output logic                  div_zero
`endif
);

    localparam int CNT_W = (DIVIDEND_W > 1) ? $clog2(DIVIDEND_W) : 1;

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        DONE
    } state_t;

    state_t state, state_nxt;

    logic [DIVIDEND_W-1:0] dvd;      // dividend, shifted out MSB first
    logic [DIVISOR_W-1:0]  dvs;      // latched divisor
    logic [DIVISOR_W-1:0]  pr;       // partial remainder between iterations
    logic [DIVIDEND_W-1:0] q;        // quotient being assembled
    logic [CNT_W-1:0]      count;

    logic                  accept;
    logic                  last;
    logic                  zero_fast;

    // Iteration datapath
    logic [DIVISOR_W:0]    pr_sh;    // shifted partial remainder (DIVISOR_W+1 bits)
    logic                  trial_ok; // pr_sh - divisor >= 0
    logic [DIVISOR_W-1:0]  diff;

    assign in_ready = (state == IDLE);
    assign accept   = in_valid && (state == IDLE);
    assign last     = (count == '0);

`ifdef DIV_ZERO_ERR_EN
    assign zero_fast = (divisor == '0);
    logic dz_pend;
`else
    assign zero_fast = 1'b0;
`endif

    assign pr_sh    = {pr, dvd[DIVIDEND_W-1]};
    assign trial_ok = (pr_sh >= {1'b0, dvs});
    // A successful trial always leaves a value below 2**DIVISOR_W (it is
    // either < divisor, or the low bits of pr_sh when divisor is zero), so
    // the subtraction can be done modulo 2**DIVISOR_W.
    assign diff     = pr_sh[DIVISOR_W-1:0] - dvs;

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: begin
                if (accept) begin
                    state_nxt = zero_fast ? DONE : CALC;
                end
            end
            CALC: begin
                if (last) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                if (out_valid && out_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath and output registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dvd       <= '0;
            dvs       <= '0;
            pr        <= '0;
            q         <= '0;
            count     <= '0;
            out_valid <= 1'b0;
            quotient  <= '0;
            remainder <= '0;
`ifdef DIV_ZERO_ERR_EN
            dz_pend   <= 1'b0;
            div_zero  <= 1'b0;
`endif
        end else begin
            unique case (state)
                IDLE: begin
                    if (accept) begin
                        dvd   <= dividend;
                        dvs   <= divisor;
                        count <= CNT_W'(DIVIDEND_W - 1);
`ifdef DIV_ZERO_ERR_EN
                        dz_pend  <= zero_fast;
                        div_zero <= 1'b0;
`endif
                        if (zero_fast) begin
                            // Same result the full iteration would give.
                            q  <= '1;
                            pr <= dividend[DIVISOR_W-1:0];
                        end else begin
                            q  <= '0;
                            pr <= '0;
                        end
                    end
                end
                CALC: begin
                    dvd <= dvd << 1;
                    q   <= {q[DIVIDEND_W-2:0], trial_ok};
                    pr  <= trial_ok ? diff : pr_sh[DIVISOR_W-1:0];
                    if (!last) begin
                        count <= count - 1'b1;
                    end
                end
                DONE: begin
                    if (!out_valid) begin
                        out_valid <= 1'b1;
                        quotient  <= q;
                        remainder <= pr;
`ifdef DIV_ZERO_ERR_EN
                        div_zero  <= dz_pend;
`endif
                    end else if (out_ready) begin
                        out_valid <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_seq_divider_16by8.sv
// ----------------------------------------------------------------------------
// tb_seq_divider_16by8
//   Self-checking bench for seq_divider_16by8. Expected results are computed
//   when operands are accepted, pushed to a scoreboard queue and popped when
//   the divider presents a result. Honours DIV_ZERO_ERR_EN when defined.
// ----------------------------------------------------------------------------
module tb_seq_divider_16by8;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] dividend;
    logic [7:0]  divisor;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] quotient;
    logic [7:0]  remainder;
`ifdef DIV_ZERO_ERR_EN
    logic        div_zero;
`endif

    typedef struct {
        logic [15:0] q;
        logic [7:0]  r;
        logic        dz;
        int          lat;
    } exp_t;

    exp_t sb[$];

    int n_checks = 0;
    int n_fail   = 0;

    seq_divider_16by8 #(
        .DIVIDEND_W(16),
        .DIVISOR_W (8)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .dividend (dividend),
        .divisor  (divisor),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .quotient (quotient),
        .remainder(remainder)
`ifdef DIV_ZERO_ERR_EN
        ,
        .div_zero (div_zero)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model of one division.
    function automatic exp_t model(input logic [15:0] a, input logic [7:0] b);
        exp_t e;
        if (b == 8'd0) begin
            e.q  = 16'hFFFF;
            e.r  = a[7:0];
`ifdef DIV_ZERO_ERR_EN
            e.dz  = 1'b1;
            e.lat = 1;
`else
            e.dz  = 1'b0;
            e.lat = 17;
`endif
        end else begin
            e.q   = a / {8'd0, b};
            e.r   = 8'(a % {8'd0, b});
            e.dz  = 1'b0;
            e.lat = 17;
        end
        return e;
    endfunction

    // Present operands until accepted; push the expected result on accept.
    // Returns #1 after the accept edge.
    task automatic send(input logic [15:0] a, input logic [7:0] b, output bit ok);
        dividend = a;
        divisor  = b;
        in_valid = 1'b1;
        ok       = 1'b0;
        for (int i = 0; i < 200 && !ok; i++) begin
            if (in_ready) ok = 1'b1;
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        if (ok) sb.push_back(model(a, b));
    endtask

    // Count clock edges until out_valid is seen (bounded).
    task automatic wait_result(output int lat);
        lat = 0;
        while (!out_valid && lat < 200) begin
            @(posedge clk);
            #1;
            lat++;
        end
    endtask

    task automatic drain();
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        dividend  = '0;
        divisor   = '0;
        repeat (3) @(posedge clk);
        #1;
        n_checks++;
        if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
        n_checks++;
        if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
        n_checks++;
        if (quotient !== 16'd0) begin n_fail++; $display("FAIL reset_quotient got %0d want 0", quotient); end
        n_checks++;
        if (remainder !== 8'd0) begin n_fail++; $display("FAIL reset_remainder got %0d want 0", remainder); end
`ifdef DIV_ZERO_ERR_EN
        n_checks++;
        if (div_zero !== 1'b0) begin n_fail++; $display("FAIL reset_div_zero got %b want 0", div_zero); end
`endif
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    // Run one operation and check latency and result against the scoreboard.
    task automatic test_op(input logic [15:0] a, input logic [7:0] b, input string tag);
        bit   ok;
        int   lat;
        exp_t e;
        send(a, b, ok);
        n_checks++;
        if (!ok) begin n_fail++; $display("FAIL %s_accept got not-accepted want accepted", tag); return; end
        wait_result(lat);
        e = sb.pop_front();
        n_checks++;
        if (lat !== e.lat) begin n_fail++; $display("FAIL %s_latency got %0d want %0d", tag, lat, e.lat); end
        n_checks++;
        if (quotient !== e.q) begin n_fail++; $display("FAIL %s_quotient got %0d want %0d", tag, quotient, e.q); end
        n_checks++;
        if (remainder !== e.r) begin n_fail++; $display("FAIL %s_remainder got %0d want %0d", tag, remainder, e.r); end
`ifdef DIV_ZERO_ERR_EN
        n_checks++;
        if (div_zero !== e.dz) begin n_fail++; $display("FAIL %s_div_zero got %b want %b", tag, div_zero, e.dz); end
`endif
        drain();
    endtask

    task automatic test_basic();
        test_op(16'd1000, 8'd7, "d1000_7");
        // Independent constant check of the reference model's first case.
        n_checks++;
        if (quotient !== 16'd142 || remainder !== 8'd6) begin
            n_fail++; $display("FAIL const_1000_7 got %0d r%0d want 142 r6", quotient, remainder);
        end
    endtask

    task automatic test_corners();
        test_op(16'd65025, 8'd255, "d65025_255");
        test_op(16'd65535, 8'd1,   "d65535_1");
        test_op(16'd100,   8'd200, "d100_200");
        test_op(16'd0,     8'd5,   "d0_5");
        test_op(16'd14450, 8'd85,  "d14450_85");
    endtask

    task automatic test_roundtrip();
        for (int i = 0; i < 10; i++) begin
            int a;
            int b;
            a = $urandom_range(255, 0);
            b = $urandom_range(255, 1);
            test_op(16'(a * b), 8'(b), "roundtrip");
            n_checks++;
            if ({16'd0, quotient} !== 32'(a) || remainder !== 8'd0) begin
                n_fail++;
                $display("FAIL roundtrip_product %0d*%0d got %0d r%0d want %0d r0", a, b, quotient, remainder, a);
            end
        end
    endtask

    task automatic test_backpressure();
        bit   ok;
        int   lat;
        exp_t e;
        send(16'd1000, 8'd7, ok);
        wait_result(lat);
        e = sb.pop_front();
        n_checks++;
        if (lat !== 17) begin n_fail++; $display("FAIL bp_latency got %0d want 17", lat); end
        // Offer the next operation while the result is still pending.
        dividend = 16'd50;
        divisor  = 8'd5;
        in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            n_checks++;
            if (out_valid !== 1'b1 || quotient !== e.q || remainder !== e.r || in_ready !== 1'b0) begin
                n_fail++;
                $display("FAIL bp_hold cycle %0d got v=%b q=%0d r=%0d rdy=%b want v=1 q=%0d r=%0d rdy=0",
                         i, out_valid, quotient, remainder, in_ready, e.q, e.r);
            end
        end
        drain();
        n_checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            n_fail++; $display("FAIL bp_after_drain got v=%b rdy=%b want v=0 rdy=1", out_valid, in_ready);
        end
        send(16'd50, 8'd5, ok);
        wait_result(lat);
        e = sb.pop_front();
        n_checks++;
        if (quotient !== 16'd10 || remainder !== 8'd0 || lat !== 17) begin
            n_fail++; $display("FAIL bp_next got %0d r%0d lat %0d want 10 r0 lat 17", quotient, remainder, lat);
        end
        drain();
    endtask

    task automatic test_div_zero();
        test_op(16'd1234, 8'd0, "d1234_0");
        n_checks++;
        if (quotient !== 16'hFFFF || remainder !== 8'hD2) begin
            n_fail++; $display("FAIL const_1234_0 got %h r%h want ffff rd2", quotient, remainder);
        end
        test_op(16'd9, 8'd3, "d9_3_after_zero");
    endtask

    task automatic test_reset_mid();
        bit ok;
        int seen;
        send(16'd1000, 8'd7, ok);
        repeat (8) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        void'(sb.pop_back());
        n_checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || quotient !== 16'd0 || remainder !== 8'd0) begin
            n_fail++;
            $display("FAIL midreset_values got rdy=%b v=%b q=%0d r=%0d want rdy=1 v=0 q=0 r=0",
                     in_ready, out_valid, quotient, remainder);
        end
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        seen = 0;
        for (int i = 0; i < 25; i++) begin
            @(posedge clk);
            #1;
            if (out_valid) seen++;
        end
        n_checks++;
        if (seen !== 0) begin n_fail++; $display("FAIL midreset_spurious got %0d valid cycles want 0", seen); end
        test_op(16'd81, 8'd9, "d81_9");
    endtask

    initial begin
        test_reset();
        test_basic();
        test_corners();
        test_roundtrip();
        test_backpressure();
        test_div_zero();
        test_reset_mid();
        n_checks++;
        if (sb.size() !== 0) begin n_fail++; $display("FAIL scoreboard_empty got %0d want 0", sb.size()); end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
